// File: rtl/majority_bist_pkg.sv
// Shared types, pattern constants and the reference majority function for the
// majority gate self-test engine.
package majority_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam int              PAT_W    = 3;
  localparam int              NUM_PAT  = 8;
  localparam logic [PAT_W-1:0] LAST_PAT = 3'd7;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/majority_golden.sv
// Combinational reference model: expected majority output for a packed pattern
// where bit 0 is a, bit 1 is b and bit 2 is c.
module majority_golden
  import majority_bist_pkg::*;
(
  input  logic [PAT_W-1:0] i_pattern,
  output logic             o_expected
);

  assign o_expected = majority3(i_pattern[0], i_pattern[1], i_pattern[2]);

endmodule

// File: rtl/majority_bist.sv
// Exhaustive self-test for a 3-input majority gate: walks all eight patterns,
// holds each SETTLE_CYCLES cycles, samples dut_out and scores it against golden.
module majority_bist
  import majority_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [PAT_W-1:0] dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [PAT_W-1:0] first_fail,
  output logic             check_valid,
  output logic [PAT_W-1:0] check_pattern,
  output logic             check_result
);

  localparam int               CNT_W    = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [PAT_W-1:0] r_pattern;
  logic [CNT_W-1:0] r_cnt;
  logic [ERR_W-1:0] r_err_count;
  logic             r_fail_valid;
  logic [PAT_W-1:0] r_first_fail;
  logic             r_check_valid;
  logic [PAT_W-1:0] r_check_pattern;
  logic             r_check_result;

  logic w_launch;
  logic w_sample;
  logic w_expected;
  logic w_mismatch;
  logic w_err_sat;

  majority_golden u_golden (
    .i_pattern  (r_pattern),
    .o_expected (w_expected)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_launch     = 1'b1;
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == LAST_CNT) begin
          w_state_next = CHECK;
        end
      end
      CHECK: begin
        w_sample     = 1'b1;
        w_state_next = (r_pattern == LAST_PAT) ? DONE : WAIT;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_mismatch = w_sample & (dut_out != w_expected);
  assign w_err_sat  = &r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern       <= '0;
      r_cnt           <= '0;
      r_err_count     <= '0;
      r_fail_valid    <= 1'b0;
      r_first_fail    <= '0;
      r_check_valid   <= 1'b0;
      r_check_pattern <= '0;
      r_check_result  <= 1'b0;
    end else begin
      r_check_valid <= w_sample;
      if (w_launch) begin
        r_pattern    <= '0;
        r_cnt        <= '0;
        r_err_count  <= '0;
        r_fail_valid <= 1'b0;
        r_first_fail <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_sample) begin
        r_check_pattern <= r_pattern;
        r_check_result  <= dut_out;
        r_cnt           <= '0;
        // The last pattern stays on dut_in through DONE; no wrap to 0.
        if (r_pattern != LAST_PAT) begin
          r_pattern <= r_pattern + PAT_W'(1);
        end
        if (w_mismatch) begin
          if (!w_err_sat) begin
            r_err_count <= r_err_count + ERR_W'(1);
          end
          if (!r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_first_fail <= r_pattern;
          end
        end
      end
    end
  end

  assign dut_in        = r_pattern;
  assign busy          = (r_state == WAIT) || (r_state == CHECK);
  assign done          = (r_state == DONE);
  assign pass          = done && (r_err_count == '0);
  assign err_count     = r_err_count;
  assign fail_valid    = r_fail_valid;
  assign first_fail    = r_first_fail;
  assign check_valid   = r_check_valid;
  assign check_pattern = r_check_pattern;
  assign check_result  = r_check_result;

endmodule

// File: tb/tb_majority_bist.sv
// Scoreboard bench: three engines (default, ERR_W=2, SETTLE_CYCLES=1) each
// driving a behavioural majority DUT whose fault mode is selectable.
module tb_majority_bist;

  typedef struct packed {
    logic [2:0] pattern;
    logic       result;
  } exp_t;

  // Hand-computed majority results for patterns 7..0: 1,1,1,0,1,0,0,0
  localparam logic [7:0] MAJ_TABLE = 8'hE8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = 3'b000;
  logic [2:0] dut_out_v;
  logic [2:0] busy_v, done_v, pass_v, fv_v, cv_v, cres_v;
  logic [2:0] din_v  [3];
  logic [2:0] ff_v   [3];
  logic [2:0] cpat_v [3];
  logic [3:0] err0, err2;
  logic [1:0] err1;

  int   mode_v [3] = '{0, 2, 0};
  exp_t q [3][$];
  int   last_cv [3] = '{-1, -1, -1};
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic model_out(input int mode, input logic [2:0] p);
    logic [7:0] t;
    t = MAJ_TABLE;
    case (mode)
      1:       return 1'b0;
      2:       return ~t[p];
      default: return t[p];
    endcase
  endfunction

  assign dut_out_v[0] = model_out(mode_v[0], din_v[0]);
  assign dut_out_v[1] = model_out(mode_v[1], din_v[1]);
  assign dut_out_v[2] = model_out(mode_v[2], din_v[2]);

  majority_bist u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .dut_in(din_v[0]), .dut_out(dut_out_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err0),
    .fail_valid(fv_v[0]), .first_fail(ff_v[0]), .check_valid(cv_v[0]),
    .check_pattern(cpat_v[0]), .check_result(cres_v[0])
  );

  majority_bist #(.SETTLE_CYCLES(4), .ERR_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .dut_in(din_v[1]), .dut_out(dut_out_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err1),
    .fail_valid(fv_v[1]), .first_fail(ff_v[1]), .check_valid(cv_v[1]),
    .check_pattern(cpat_v[1]), .check_result(cres_v[1])
  );

  majority_bist #(.SETTLE_CYCLES(1), .ERR_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .dut_in(din_v[2]), .dut_out(dut_out_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err2),
    .fail_valid(fv_v[2]), .first_fail(ff_v[2]), .check_valid(cv_v[2]),
    .check_pattern(cpat_v[2]), .check_result(cres_v[2])
  );

  function automatic int err_of(input int i);
    if (i == 0) return int'(err0);
    if (i == 1) return int'(err1);
    return int'(err2);
  endfunction

  function automatic int interval_of(input int i);
    return (i == 2) ? 2 : 5;
  endfunction

  task automatic chk(input string name, input int inst, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s inst%0d actual=%0d required=%0d", name, inst, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every check strobe.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (cv_v[i] === 1'b1) begin
        $display("inst%0d check pattern=%0d result=%0d cyc=%0d", i, cpat_v[i], cres_v[i], cyc);
        if (q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_check inst%0d actual pattern=%0d required=no strobe", i, cpat_v[i]);
        end else begin
          e = q[i].pop_front();
          chk("check_pattern", i, int'(cpat_v[i]), int'(e.pattern));
          chk("check_result", i, int'(cres_v[i]), int'(e.result));
        end
        if (last_cv[i] >= 0) chk("check_interval", i, cyc - last_cv[i], interval_of(i));
        last_cv[i] = cyc;
      end
    end
  end

  // One full run; the start-sampling edge counts as cycle 1.
  task automatic do_run(input int i, input int mode, input int extra_at, input int exp_cycles,
                        input int exp_err, input int exp_fv, input int exp_ff);
    int cycles;
    mode_v[i] = mode;
    for (int p = 0; p < 8; p++) q[i].push_back('{pattern: 3'(p), result: model_out(mode, 3'(p))});
    last_cv[i] = -1;
    @(negedge clk);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    cycles = 1;
    chk("launch_busy", i, int'(busy_v[i]), 1);
    chk("launch_done", i, int'(done_v[i]), 0);
    chk("launch_err", i, err_of(i), 0);
    chk("launch_fail_valid", i, int'(fv_v[i]), 0);
    chk("launch_dut_in", i, int'(din_v[i]), 0);
    while (!done_v[i] && cycles < 300) begin
      start_v[i] = (cycles == extra_at);
      @(negedge clk);
      cycles++;
    end
    start_v[i] = 1'b0;
    chk("done_latency", i, cycles, exp_cycles);
    @(negedge clk);
    chk("done_level", i, int'(done_v[i]), 1);
    chk("busy_end", i, int'(busy_v[i]), 0);
    chk("pass", i, int'(pass_v[i]), (exp_err == 0) ? 1 : 0);
    chk("err_count", i, err_of(i), exp_err);
    chk("fail_valid", i, int'(fv_v[i]), exp_fv);
    chk("first_fail", i, int'(ff_v[i]), exp_ff);
    chk("dut_in_held", i, int'(din_v[i]), 7);
    chk("scoreboard_drained", i, q[i].size(), 0);
    $display("inst%0d run mode=%0d cycles=%0d err=%0d pass=%0d", i, mode, cycles, err_of(i), pass_v[i]);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 0, int'(busy_v[0]), 0);
    chk({tag, "_done"}, 0, int'(done_v[0]), 0);
    chk({tag, "_pass"}, 0, int'(pass_v[0]), 0);
    chk({tag, "_err"}, 0, err_of(0), 0);
    chk({tag, "_fail_valid"}, 0, int'(fv_v[0]), 0);
    chk({tag, "_first_fail"}, 0, int'(ff_v[0]), 0);
    chk({tag, "_check_valid"}, 0, int'(cv_v[0]), 0);
    chk({tag, "_check_pattern"}, 0, int'(cpat_v[0]), 0);
    chk({tag, "_check_result"}, 0, int'(cres_v[0]), 0);
    chk({tag, "_dut_in"}, 0, int'(din_v[0]), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog inst0 actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cycles;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_busy", 1, int'(busy_v[1]), 0);
    chk("reset_done", 2, int'(done_v[2]), 0);
    rst = 1'b0;
    @(negedge clk);

    do_run(0, 0, -1, 41, 0, 0, 0);     // correct DUT
    do_run(0, 0, 7, 41, 0, 0, 0);      // start during WAIT ignored
    do_run(0, 1, -1, 41, 4, 1, 3);     // stuck-at-0, restarted from DONE
    do_run(0, 0, -1, 41, 0, 0, 0);     // restart from DONE clears errors

    // Reset while check_pattern reports 4.
    mode_v[0] = 0;
    for (int p = 0; p < 5; p++) q[0].push_back('{pattern: 3'(p), result: model_out(0, 3'(p))});
    last_cv[0] = -1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    cycles = 0;
    while (!(cv_v[0] && cpat_v[0] == 3'd4) && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    chk("reach_pattern4", 0, (cycles < 300) ? 1 : 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrun_reset");
    rst = 1'b0;
    @(negedge clk);
    chk("midrun_reset_busy", 0, int'(busy_v[0]), 0);
    chk("midrun_scoreboard", 0, q[0].size(), 0);
    do_run(0, 0, -1, 41, 0, 0, 0);     // fresh run after abort

    do_run(1, 2, -1, 41, 3, 1, 0);     // inverting DUT, ERR_W=2 saturates
    do_run(2, 0, -1, 17, 0, 0, 0);     // SETTLE_CYCLES=1

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/majority_bist.md
Name: majority_bist

Overview:
- Built-in self-test engine for the 3-input majority gate.
- Drives all eight input patterns onto a majority DUT, waits a programmable settle time, and samples the DUT output. Compares each sample against a golden majority function.
- Reports error count, first failing pattern and pass/fail.
- Hardware counterpart of the exhaustive majority stimulus/display bench. It sits beside the majority instance in lab top levels.

Parameters:
- SETTLE_CYCLES, 4, cycles dut_in is held before dut_out is sampled; legal range 1..255.
- ERR_W, 4, width of err_count; saturating counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  launch pulse; honoured only in IDLE or DONE
- dut_in  output  3  pattern to DUT; dut_in[0]=a, dut_in[1]=b, dut_in[2]=c
- dut_out  input  1  majority DUT output
- busy  output  1  high while a test run is in progress
- done  output  1  level; high in DONE until next start or rst
- pass  output  1  done && err_count==0
- err_count  output  ERR_W  mismatches this run, saturates at 2^ERR_W-1
- fail_valid  output  1  at least one mismatch recorded this run
- first_fail  output  3  pattern of first mismatch; valid when fail_valid
- check_valid  output  1  one-cycle pulse per sampled pattern (log strobe)
- check_pattern  output  3  pattern sampled, valid with check_valid
- check_result  output  1  dut_out sampled, valid with check_valid

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - dut_in, err_count and first_fail are 0.
  - busy, done, pass, fail_valid and check_valid are 0.
  - Reset mid-run aborts immediately with no partial done.
- FSM states:
  - IDLE: start -> WAIT. Sets pattern=0, settle counter=0, busy=1. Clears err_count, fail_valid, first_fail and done.
  - WAIT: dut_in=pattern held; counter increments each cycle. When counter==SETTLE_CYCLES-1 -> CHECK.
  - CHECK (one cycle): sample dut_out and pulse check_valid/check_pattern/check_result on the following edge.
    - Mismatch vs expected = (a&b)|(a&c)|(b&c): err_count+1 (saturating).
    - On the first mismatch only: set fail_valid=1 and first_fail=pattern.
    - If pattern==7 -> DONE, busy=0, done=1.
    - Otherwise pattern+1 -> WAIT with counter=0.
  - DONE: outputs held. start -> same action as in IDLE (done drops the next cycle).
- start while busy is ignored with no effect.
- dut_in remains at the last pattern (3'b111) in DONE. It returns to 0 only on a new start or rst.
- Per-pattern time: SETTLE_CYCLES+1 cycles.
- done rises 1 + 8*(SETTLE_CYCLES+1) cycles after the edge sampling start (41 for default).
- Pattern counter is 3 bits; termination is by the explicit pattern==7 check, never by wrap-around.
- Errors on simultaneous events:
  - Saturation and first-mismatch capture are independent: saturation does not block first_fail.
  - A mismatch at pattern 7 still updates err_count on the same edge done rises; pass reflects it.

Decomposition:
- Package majority_bist_pkg holds:
  - state enum {IDLE, WAIT, CHECK, DONE}
  - PAT_W=3, NUM_PAT=8, LAST_PAT=3'd7
  - function majority3(a,b,c)
- One sub-module: majority_golden. It is a combinational reference model wrapping majority3, instanced in the CHECK compare path.
- Counters and FSM live in majority_bist.

Test Plan:
- Correct majority DUT, defaults, start pulse:
  - done at +41 cycles, pass=1, err_count=0, fail_valid=0.
  - 8 check_valid pulses, patterns 0..7, results 0,0,0,1,0,1,1,1.
- DUT stuck-at-0:
  - err_count=4, fail_valid=1, first_fail=3'b011, pass=0.
- Inverting DUT with ERR_W=2:
  - err_count saturates at 3, first_fail=3'b000, pass=0.
- rst asserted while check_pattern=4:
  - Next cycle all outputs 0, busy=0.
  - A fresh start then completes a normal 41-cycle run.
- start pulsed during WAIT is ignored (run still ends at +41).
- start in DONE restarts: done=0 and err_count=0 one cycle later.
- SETTLE_CYCLES=1:
  - done at +17 cycles.
  - dut_in changes every 2 cycles and sample ordering is correct.
